// File: rtl/gddr_cfg_sequencer_if.sv
// CSR config request/ack bus between the sequencer and the NAP CSR master.
// master: drives tgt_id/wr_rdn/addr/wdata/req; slave: returns rdata/ack.
interface gddr_cfg_sequencer_if #(
  parameter int AW = 28,
  parameter int DW = 32
);
  logic [5:0]    tgt_id;
  logic          wr_rdn;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          req;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (
    output tgt_id, wr_rdn, addr, wdata, req,
    input  rdata, ack
  );

  modport slave (
    input  tgt_id, wr_rdn, addr, wdata, req,
    output rdata, ack
  );
endinterface

// File: rtl/gddr_cfg_sequencer.sv
// Walks a ROM command table (END/WRITE/POLL/DELAY) and drives the cfg bus.
// Ports: clk/reset, i_start, ROM addr/data, cfg master, busy/done/error.
module gddr_cfg_sequencer #(
  parameter int CFG_ADDR_WIDTH = 28,
  parameter int CFG_DATA_WIDTH = 32,
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int POLL_MAX       = 1024,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                      i_cfg_clk,
  input  logic                      i_cfg_reset_n,
  input  logic                      i_start,
  output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [2+6+CFG_ADDR_WIDTH+2*CFG_DATA_WIDTH-1:0] i_rom_data,
  gddr_cfg_sequencer_if.master      cfg,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [ROM_ADDR_WIDTH-1:0] o_err_index
);

  localparam int AW = CFG_ADDR_WIDTH;
  localparam int DW = CFG_DATA_WIDTH;
  localparam int RA = ROM_ADDR_WIDTH;
  localparam int RW = 2 + 6 + AW + 2 * DW;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_GAP,
    S_DELAY
  } state_t;

  state_t        state_q, state_d;
  logic [RA-1:0] rom_addr_q, rom_addr_d;
  logic [5:0]    tgt_q, tgt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] mask_q, mask_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [RA-1:0] err_idx_q, err_idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          adv_q, adv_d;

  logic [1:0]    e_op;
  logic [5:0]    e_tgt;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [DW-1:0] e_mask;
  logic          op_end, op_wr, op_poll, op_dly;
  logic          match;

  assign e_op   = i_rom_data[RW-1 -: 2];
  assign e_tgt  = i_rom_data[RW-3 -: 6];
  assign e_addr = i_rom_data[2*DW +: AW];
  assign e_data = i_rom_data[DW +: DW];
  assign e_mask = i_rom_data[0 +: DW];

  assign op_end  = (e_op == 2'b00);
  assign op_wr   = (e_op == 2'b01);
  assign op_poll = (e_op == 2'b10);
  assign op_dly  = (e_op == 2'b11);

  // Poll expectation lives in wdata_q; only masked bits are compared.
  assign match = (((cfg.rdata ^ wdata_q) & mask_q) == '0);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    tgt_d      = tgt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    req_d      = req_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    poll_d     = poll_q;
    gap_d      = gap_q;
    dly_d      = dly_q;
    adv_d      = adv_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_idx_d  = '0;
          rom_addr_d = '0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          op_end: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
          op_wr, op_poll: begin
            tgt_d   = e_tgt;
            addr_d  = e_addr;
            wdata_d = e_data;
            mask_d  = e_mask;
            wr_d    = op_wr;
            req_d   = 1'b1;
            poll_d  = '0;
            state_d = S_REQ;
          end
          op_dly: begin
            if (e_data == '0) begin
              rom_addr_d = rom_addr_q + 1'b1;
              state_d    = S_FETCH;
            end else begin
              dly_d   = e_data;
              state_d = S_DELAY;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_REQ: begin
        if (cfg.ack) begin
          req_d = 1'b0;
          gap_d = '0;
          if (wr_q || match) begin
            adv_d   = 1'b1;
            state_d = S_GAP;
          end else if (poll_q < POLL_LAST) begin
            poll_d  = poll_q + 1'b1;
            adv_d   = 1'b0;
            state_d = S_GAP;
          end else begin
            err_d     = 1'b1;
            err_idx_d = rom_addr_q;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (adv_q) begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = S_FETCH;
          end else begin
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DELAY: begin
        if (dly_q == DLY_LAST) begin
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = S_FETCH;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_cfg_clk or negedge i_cfg_reset_n) begin
    if (!i_cfg_reset_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      tgt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      poll_q     <= '0;
      gap_q      <= '0;
      dly_q      <= '0;
      adv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      tgt_q      <= tgt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      poll_q     <= poll_d;
      gap_q      <= gap_d;
      dly_q      <= dly_d;
      adv_q      <= adv_d;
    end
  end

  assign o_rom_addr  = rom_addr_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = err_q;
  assign o_err_index = err_idx_q;
  assign cfg.tgt_id  = tgt_q;
  assign cfg.wr_rdn  = wr_q;
  assign cfg.addr    = addr_q;
  assign cfg.wdata   = wdata_q;
  assign cfg.req     = req_q;

endmodule

// File: tb/tb_gddr_cfg_sequencer.sv
// Directed bench for gddr_cfg_sequencer with ROM model and cfg responder.
// The DUT runs with POLL_MAX=4 so poll limits are reachable quickly.
module tb_gddr_cfg_sequencer;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int RA = 8;
  localparam int RW = 2 + 6 + AW + 2 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [RA-1:0] rom_addr;
  logic [RW-1:0] rom_data = '0;
  logic busy, done, error;
  logic [RA-1:0] err_index;
  logic [RW-1:0] rom [256];

  int n_pass = 0;
  int n_tot = 0;

  // monitor / responder state
  int req_cnt, hi_len, low_len, min_gap, stab_err, fall_err;
  int ack_lat, ack_limit, acks, lat, rd_i;
  logic req_prev, ack_prev, have_fall;
  logic [DW-1:0] rd_vals [8];
  logic [5:0] f_tgt;
  logic f_wr;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata;
  logic [6+1+AW+DW-1:0] cur_f;

  gddr_cfg_sequencer_if #(.AW(AW), .DW(DW)) cfg ();

  gddr_cfg_sequencer #(.POLL_MAX(4)) dut (
    .i_cfg_clk    (clk),
    .i_cfg_reset_n(rst_n),
    .i_start      (start),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .cfg          (cfg.master),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_err_index  (err_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [RW-1:0] ent(
    input logic [1:0] op, input logic [5:0] t,
    input logic [AW-1:0] a, input logic [DW-1:0] d,
    input logic [DW-1:0] m);
    return {op, t, a, d, m};
  endfunction

  initial begin
    cfg.ack = 1'b0;
    cfg.rdata = '0;
    req_prev = 1'b0;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg.req) begin
        if (!req_prev) begin
          req_cnt++;
          hi_len = 1;
          cur_f = {cfg.tgt_id, cfg.wr_rdn, cfg.addr, cfg.wdata};
          if (req_cnt == 1) begin
            f_tgt = cfg.tgt_id; f_wr = cfg.wr_rdn;
            f_addr = cfg.addr; f_wdata = cfg.wdata;
          end
          if (have_fall && low_len < min_gap) min_gap = low_len;
        end else begin
          hi_len++;
          if ({cfg.tgt_id, cfg.wr_rdn, cfg.addr, cfg.wdata} !== cur_f)
            stab_err++;
        end
      end else begin
        if (req_prev) begin low_len = 0; have_fall = 1'b1; end
        low_len++;
      end
      if (ack_prev && cfg.req) fall_err++;
      if (cfg.ack) begin
        cfg.ack = 1'b0;
      end else if (cfg.req && acks < ack_limit) begin
        lat++;
        if (lat >= ack_lat) begin
          cfg.ack = 1'b1;
          cfg.rdata = (rd_i < 8) ? rd_vals[rd_i] : '0;
          rd_i++;
          acks++;
          lat = 0;
        end
      end else begin
        lat = 0;
      end
      ack_prev = cfg.ack;
      req_prev = cfg.req;
    end
  end

  task automatic clear_mon();
    req_cnt = 0; hi_len = 0; low_len = 0; min_gap = 1000;
    stab_err = 0; fall_err = 0; have_fall = 1'b0;
    acks = 0; lat = 0; rd_i = 0; ack_limit = 1000; ack_lat = 3;
    for (int i = 0; i < 8; i++) rd_vals[i] = '0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic run_start(output int lat_out);
    @(negedge clk);
    start = 1'b1;
    lat_out = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (cfg.req === 1'b1) begin lat_out = k; break; end
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    n_tot++;
    if (k >= 3000) $display("FAIL %s_timeout: busy still %b", name, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tot++;
    if ({busy, done, error, err_index} !== '0)
      $display("FAIL reset_status: got %b%b%b %h want 0", busy, done, error, err_index);
    else n_pass++;
    n_tot++;
    if (rom_addr !== '0) $display("FAIL reset_rom_addr: got %h want 0", rom_addr);
    else n_pass++;
    n_tot++;
    if ({cfg.req, cfg.wr_rdn, cfg.tgt_id, cfg.addr, cfg.wdata} !== '0)
      $display("FAIL reset_cfg: req %b addr %h want 0", cfg.req, cfg.addr);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    int l;
    clear_rom(); clear_mon();
    rom[0] = ent(2'd1, 6'h12, 28'h100, 32'hA5A5A5A5, 32'h0);
    ack_lat = 5;
    run_start(l);
    n_tot++;
    if (l !== 3) $display("FAIL write_latency: got %0d want 3", l); else n_pass++;
    wait_idle("write");
    n_tot++;
    if ({f_tgt, f_wr, f_addr, f_wdata} !== {6'h12, 1'b1, 28'h100, 32'hA5A5A5A5})
      $display("FAIL write_fields: got %h %b %h %h", f_tgt, f_wr, f_addr, f_wdata);
    else n_pass++;
    n_tot++;
    if (hi_len !== 5) $display("FAIL write_req_len: got %0d want 5", hi_len); else n_pass++;
    n_tot++;
    if (req_cnt !== 1) $display("FAIL write_req_cnt: got %0d want 1", req_cnt); else n_pass++;
    n_tot++;
    if (stab_err !== 0 || fall_err !== 0)
      $display("FAIL write_hold: stab %0d fall %0d want 0", stab_err, fall_err);
    else n_pass++;
    n_tot++;
    if ({done, error, busy} !== 3'b100)
      $display("FAIL write_status: got d%b e%b b%b want 100", done, error, busy);
    else n_pass++;
  endtask

  task automatic test_poll();
    int l;
    clear_rom(); clear_mon();
    rom[0] = ent(2'd2, 6'h05, 28'h200, 32'h1, 32'h1);
    rd_vals[0] = 32'hFFFF_FFFE; rd_vals[1] = 32'h0; rd_vals[2] = 32'h0000_0F01;
    run_start(l);
    wait_idle("poll");
    n_tot++;
    if (req_cnt !== 3) $display("FAIL poll_req_cnt: got %0d want 3", req_cnt); else n_pass++;
    n_tot++;
    if (f_wr !== 1'b0) $display("FAIL poll_wr_rdn: got %b want 0", f_wr); else n_pass++;
    n_tot++;
    if (min_gap !== 2) $display("FAIL poll_gap: got %0d want 2", min_gap); else n_pass++;
    n_tot++;
    if (stab_err !== 0 || fall_err !== 0)
      $display("FAIL poll_hold: stab %0d fall %0d want 0", stab_err, fall_err);
    else n_pass++;
    n_tot++;
    if ({done, error} !== 2'b10)
      $display("FAIL poll_status: got d%b e%b want 10", done, error);
    else n_pass++;
  endtask

  task automatic load_poll_table();
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = ent(2'd3, 6'h0, 28'h0, 32'h0, 32'h0);
    rom[3] = ent(2'd2, 6'h07, 28'h300, 32'h5, 32'hF);
  endtask

  task automatic test_poll_timeout();
    int l, c;
    load_poll_table(); clear_mon();
    for (int i = 0; i < 8; i++) rd_vals[i] = 32'hA0;
    run_start(l);
    n_tot++;
    if (l !== 9) $display("FAIL timeout_latency: got %0d want 9", l); else n_pass++;
    wait_idle("timeout");
    n_tot++;
    if ({error, done, err_index} !== {1'b1, 1'b0, 8'd3})
      $display("FAIL timeout_status: e%b d%b idx %0d want 1 0 3", error, done, err_index);
    else n_pass++;
    c = req_cnt;
    repeat (40) @(negedge clk);
    n_tot++;
    if (req_cnt !== 4 || c !== 4)
      $display("FAIL timeout_req_cnt: got %0d/%0d want 4", c, req_cnt);
    else n_pass++;
    n_tot++;
    if (busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_poll_limit_pass();
    int l;
    load_poll_table(); clear_mon();
    rd_vals[0] = 32'hA0; rd_vals[1] = 32'hA0;
    rd_vals[2] = 32'hA0; rd_vals[3] = 32'h15;
    run_start(l);
    wait_idle("limit");
    n_tot++;
    if (req_cnt !== 4) $display("FAIL limit_req_cnt: got %0d want 4", req_cnt); else n_pass++;
    n_tot++;
    if ({done, error, err_index} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL limit_status: d%b e%b idx %0d want 1 0 0", done, error, err_index);
    else n_pass++;
  endtask

  task automatic test_delay();
    int l;
    clear_rom(); clear_mon();
    rom[0] = ent(2'd3, 6'h0, 28'h0, 32'd10, 32'h0);
    rom[1] = ent(2'd1, 6'h01, 28'h10, 32'hDEAD, 32'h0);
    run_start(l);
    n_tot++;
    if (l !== 15) $display("FAIL delay10_latency: got %0d want 15", l); else n_pass++;
    wait_idle("delay10");
    n_tot++;
    if (f_addr !== 28'h10 || done !== 1'b1)
      $display("FAIL delay10_write: addr %h done %b want 10 1", f_addr, done);
    else n_pass++;
    clear_mon();
    rom[0] = ent(2'd3, 6'h0, 28'h0, 32'd0, 32'h0);
    run_start(l);
    n_tot++;
    if (l !== 5) $display("FAIL delay0_latency: got %0d want 5", l); else n_pass++;
    wait_idle("delay0");
  endtask

  task automatic test_reset_mid();
    int l, k;
    clear_rom(); clear_mon();
    rom[0] = ent(2'd1, 6'h21, 28'h40, 32'h1111_1111, 32'h0);
    rom[1] = ent(2'd1, 6'h22, 28'h44, 32'h2222_2222, 32'h0);
    ack_lat = 2;
    ack_limit = 1;
    run_start(l);
    for (k = 0; k < 200; k++) begin
      if (req_cnt == 2) break;
      @(negedge clk);
    end
    n_tot++;
    if (k >= 200) $display("FAIL mid_second_req: req_cnt %0d want 2", req_cnt); else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_tot++;
    if (rom_addr !== 8'd1 || cfg.req !== 1'b1 || req_cnt !== 2)
      $display("FAIL busy_start: addr %0d req %b cnt %0d want 1 1 2", rom_addr, cfg.req, req_cnt);
    else n_pass++;
    n_tot++;
    if (cfg.addr !== 28'h44) $display("FAIL mid_addr: got %h want 44", cfg.addr); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_tot++;
    if ({cfg.req, busy, done, error, rom_addr, cfg.addr, cfg.wdata} !== '0)
      $display("FAIL async_reset: req %b busy %b addr %h want 0", cfg.req, busy, cfg.addr);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    run_start(l);
    n_tot++;
    if (l !== 3) $display("FAIL restart_latency: got %0d want 3", l); else n_pass++;
    wait_idle("restart");
    n_tot++;
    if (f_addr !== 28'h40 || f_tgt !== 6'h21)
      $display("FAIL restart_entry0: addr %h tgt %h want 40 21", f_addr, f_tgt);
    else n_pass++;
    n_tot++;
    if (req_cnt !== 2 || done !== 1'b1)
      $display("FAIL restart_done: cnt %0d done %b want 2 1", req_cnt, done);
    else n_pass++;
  endtask

  initial begin
    clear_rom();
    clear_mon();
    test_reset();
    test_write();
    test_poll();
    test_poll_timeout();
    test_poll_limit_pass();
    test_delay();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
